// File: rtl/multi_bit_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_bit_sync_pkg
// Description : Shared constants, helper function and edge record type for
//               the multi-bit level synchroniser.
//               Optional feature macro: MULTI_BIT_SYNC_FILTER_EN
// Revision    : 1.0 - initial release
// ============================================================================
package multi_bit_sync_pkg;

    // Fewest flops that still give a metastability settling stage.
    localparam int MIN_STAGES = 2;

    // Width needed to hold the values 0..n (at least one bit).
    function automatic int clog2_plus1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << w) < 64'(n + 1)) begin
                w = w + 1;
            end
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // Per-channel edge record for consumers that want rise/fall bundled.
    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

endpackage
`default_nettype wire

// File: rtl/multi_bit_sync_sync_chan.sv
`default_nettype none
// ============================================================================
// Module      : sync_chan
// Description : One synchroniser channel: flop chain, optional glitch filter
//               and rise/fall edge detection against a history register.
//               Optional feature macro: MULTI_BIT_SYNC_FILTER_EN
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chan
    import multi_bit_sync_pkg::*;
#(
    parameter int   NUM_STAGES = 2,
    parameter logic RST_VAL    = 1'b0,
    parameter int   FILTER_LEN = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic ASYNC,
    output logic SYNC,
    output logic RISE,
    output logic FALL
);

    logic [NUM_STAGES-1:0] r_stage;
    logic                  r_hist;
    logic                  w_s;
    logic                  w_sync;

    // Synchroniser chain: bit 0 samples the async input, the MSB is settled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stage <= {NUM_STAGES{RST_VAL}};
        end else if (EN) begin
            r_stage <= {r_stage[NUM_STAGES-2:0], ASYNC};
        end
    end

    assign w_s = r_stage[NUM_STAGES-1];

`ifdef MULTI_BIT_SYNC_FILTER_EN
    localparam int               CNT_W      = clog2_plus1(FILTER_LEN);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             r_filt;
    logic [CNT_W-1:0] r_cnt;

    // Glitch filter: follow the settled level only after it has differed
    // from the current output for FILTER_LEN consecutive enabled cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_filt <= RST_VAL;
            r_cnt  <= '0;
        end else if (EN) begin
            if (w_s == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_filt <= w_s;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_sync = r_filt;
`else
    assign w_sync = w_s;
`endif

    // Edge history: the previous enabled-cycle value of SYNC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hist <= RST_VAL;
        end else if (EN) begin
            r_hist <= w_sync;
        end
    end

    // Pulses are gated by EN so a frozen domain reports nothing; a pending
    // difference between SYNC and history pulses once EN returns.
    assign SYNC = w_sync;
    assign RISE = EN &  w_sync & ~r_hist;
    assign FALL = EN & ~w_sync &  r_hist;

endmodule
`default_nettype wire

// File: rtl/multi_bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : multi_bit_sync
// Description : BUS_WIDTH independent level synchronisers with per-channel
//               rise/fall pulses and a combined change flag. Channels are
//               NOT coherent with each other: simultaneous input changes may
//               land on different cycles. Do not use for multi-bit values.
//               Optional feature macro: MULTI_BIT_SYNC_FILTER_EN
// Revision    : 1.0 - initial release
// ============================================================================
module multi_bit_sync
    import multi_bit_sync_pkg::*;
#(
    parameter int                   BUS_WIDTH  = 1,
    parameter int                   NUM_STAGES = 2,
    parameter logic [BUS_WIDTH-1:0] RST_VAL    = {BUS_WIDTH{1'b0}},
    parameter int                   FILTER_LEN = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic [BUS_WIDTH-1:0] ASYNC,
    output logic [BUS_WIDTH-1:0] SYNC,
    output logic [BUS_WIDTH-1:0] RISE,
    output logic [BUS_WIDTH-1:0] FALL,
    output logic                 CHG
);

    // Reject configurations that cannot work at elaboration time.
    if (BUS_WIDTH < 1) begin : g_bad_width
        $error("multi_bit_sync: BUS_WIDTH must be >= 1");
    end
    if (NUM_STAGES < MIN_STAGES) begin : g_bad_stages
        $error("multi_bit_sync: NUM_STAGES must be >= MIN_STAGES");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("multi_bit_sync: FILTER_LEN must be >= 1");
    end

    // One fully independent channel per bit.
    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_chan
        sync_chan #(
            .NUM_STAGES (NUM_STAGES),
            .RST_VAL    (RST_VAL[i]),
            .FILTER_LEN (FILTER_LEN)
        ) u_chan (
            .CLK   (CLK),
            .RST   (RST),
            .EN    (EN),
            .ASYNC (ASYNC[i]),
            .SYNC  (SYNC[i]),
            .RISE  (RISE[i]),
            .FALL  (FALL[i])
        );
    end

    // Any edge on any channel this cycle.
    assign CHG = |(RISE | FALL);

endmodule
`default_nettype wire

// File: tb/tb_multi_bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_bit_sync
// Description : Directed self-checking bench for multi_bit_sync. Instance A
//               is 4 channels / 2 stages / reset 1010; instance B is one
//               channel with 3 stages. Filter-only steps are compiled when
//               MULTI_BIT_SYNC_FILTER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_bit_sync;

`ifdef MULTI_BIT_SYNC_FILTER_EN
    localparam int FLT = 4;
    localparam int PRE = 2 + 2;
`else
    localparam int FLT = 0;
    localparam int PRE = 2 - 1;
`endif
    localparam int LA = 2 + FLT;
    localparam int LB = 3 + FLT;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [3:0] a_async, a_sync, a_rise, a_fall;
    logic       a_chg;
    logic       b_async, b_sync, b_rise, b_fall, b_chg;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    multi_bit_sync #(
        .BUS_WIDTH  (4),
        .NUM_STAGES (2),
        .RST_VAL    (4'b1010),
        .FILTER_LEN (4)
    ) u_dut_a (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .ASYNC (a_async),
        .SYNC  (a_sync),
        .RISE  (a_rise),
        .FALL  (a_fall),
        .CHG   (a_chg)
    );

    multi_bit_sync #(
        .BUS_WIDTH  (1),
        .NUM_STAGES (3),
        .RST_VAL    (1'b0),
        .FILTER_LEN (4)
    ) u_dut_b (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .ASYNC (b_async),
        .SYNC  (b_sync),
        .RISE  (b_rise),
        .FALL  (b_fall),
        .CHG   (b_chg)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] s, input logic [3:0] r,
                         input logic [3:0] f, input logic c);
        chk({tag, ".sync"}, a_sync, s);
        chk({tag, ".rise"}, a_rise, r);
        chk({tag, ".fall"}, a_fall, f);
        chk({tag, ".chg"},  4'(a_chg), 4'(c));
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST     = 1'b1;
        EN      = 1'b1;
        a_async = 4'b0101;
        b_async = 1'b0;

        // Reset held three cycles.
        repeat (3) begin
            tick();
            chk_a("rst", 4'b1010, 4'b0000, 4'b0000, 1'b0);
            chk("rst_b.sync", 4'(b_sync), 4'd0);
        end

        // Release: new level arrives after the chain (and filter) latency.
        RST = 1'b0;
        for (int k = 1; k <= LA; k++) begin
            tick();
            if (k < LA) chk_a("rel_hold", 4'b1010, 4'b0000, 4'b0000, 1'b0);
            else        chk_a("rel_edge", 4'b0101, 4'b0101, 4'b1010, 1'b1);
        end
        tick();
        chk_a("rel_after", 4'b0101, 4'b0000, 4'b0000, 1'b0);

        // Three-stage latency on instance B, single-cycle RISE.
        b_async = 1'b1;
        for (int k = 1; k <= LB; k++) begin
            tick();
            if (k < LB) begin
                chk("lat_hold.sync", 4'(b_sync), 4'd0);
                chk("lat_hold.rise", 4'(b_rise), 4'd0);
            end else begin
                chk("lat_edge.sync", 4'(b_sync), 4'd1);
                chk("lat_edge.rise", 4'(b_rise), 4'd1);
                chk("lat_edge.fall", 4'(b_fall), 4'd0);
                chk("lat_edge.chg",  4'(b_chg),  4'd1);
            end
        end
        tick();
        chk("lat_after.rise", 4'(b_rise), 4'd0);
        chk("lat_after.sync", 4'(b_sync), 4'd1);

        // Enable low: inputs toggle, nothing moves.
        EN = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_async = (k % 2 == 1) ? 4'b1100 : 4'b0011;
            tick();
            chk_a("en_off", 4'b0101, 4'b0000, 4'b0000, 1'b0);
        end

        // Re-enable: latency counted from the first enabled edge.
        EN = 1'b1;
        for (int k = 1; k <= LA; k++) begin
            tick();
            if (k < LA) chk_a("en_hold", 4'b0101, 4'b0000, 4'b0000, 1'b0);
            else        chk_a("en_edge", 4'b0011, 4'b0010, 4'b0100, 1'b1);
        end
        tick();
        chk_a("en_after", 4'b0011, 4'b0000, 4'b0000, 1'b0);

        // Pending edge held over an EN-low gap pulses on re-enable.
        a_async = 4'b1111;
        for (int k = 1; k <= LA; k++) begin
            tick();
            if (k < LA) chk_a("pend_hold", 4'b0011, 4'b0000, 4'b0000, 1'b0);
            else        chk_a("pend_edge", 4'b1111, 4'b1100, 4'b0000, 1'b1);
        end
        EN = 1'b0;
        #1;
        chk_a("pend_off", 4'b1111, 4'b0000, 4'b0000, 1'b0);
        repeat (2) begin
            tick();
            chk_a("pend_frozen", 4'b1111, 4'b0000, 4'b0000, 1'b0);
        end
        EN = 1'b1;
        #1;
        chk_a("pend_resume", 4'b1111, 4'b1100, 4'b0000, 1'b1);
        tick();
        chk_a("pend_after", 4'b1111, 4'b0000, 4'b0000, 1'b0);

        // Reset while a change is still in flight.
        a_async = 4'b0000;
        repeat (PRE) begin
            tick();
            chk_a("mid_pre", 4'b1111, 4'b0000, 4'b0000, 1'b0);
        end
        RST     = 1'b1;
        a_async = 4'b1010;
        tick();
        chk_a("mid_rst", 4'b1010, 4'b0000, 4'b0000, 1'b0);
        RST = 1'b0;
        repeat (LA + 2) begin
            tick();
            chk_a("mid_post", 4'b1010, 4'b0000, 4'b0000, 1'b0);
        end

`ifdef MULTI_BIT_SYNC_FILTER_EN
        // Three-cycle glitch on channel 0 is swallowed.
        a_async = 4'b1011;
        repeat (3) begin
            tick();
            chk_a("glitch", 4'b1010, 4'b0000, 4'b0000, 1'b0);
        end
        a_async = 4'b1010;
        repeat (LA + 2) begin
            tick();
            chk_a("glitch_post", 4'b1010, 4'b0000, 4'b0000, 1'b0);
        end

        // Six-cycle pulse passes after NUM_STAGES+FILTER_LEN cycles.
        a_async = 4'b1011;
        for (int k = 1; k <= LA; k++) begin
            tick();
            if (k < LA) chk_a("filt_hold", 4'b1010, 4'b0000, 4'b0000, 1'b0);
            else        chk_a("filt_edge", 4'b1011, 4'b0001, 4'b0000, 1'b1);
        end
        a_async = 4'b1010;
        tick();
        chk_a("filt_after", 4'b1011, 4'b0000, 4'b0000, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
